// File: rtl/miriscv_fetch_pkg.sv
// Shared types and constants for the miriscv instruction fetch stage.
package miriscv_fetch_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0), shown to decode while the queue is empty.
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // Number of fetched entries buffered between memory and decode.
    localparam int unsigned FETCH_QUEUE_DEPTH = 2;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,  // no request outstanding
        FETCH_WAIT = 2'b01,  // one granted request outstanding, response kept
        FETCH_DROP = 2'b10   // one granted request outstanding, response discarded
    } fetch_state_e;

    // One queue entry: 65 bits wide.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } fetch_entry_t;

    localparam fetch_entry_t FETCH_ENTRY_RESET = {32'h0000_0000, INSTR_NOP, 1'b0};

    // Builds a word-aligned byte address from a word index.
    function automatic logic [31:0] word_addr(input logic [29:0] word_idx);
        return {word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/miriscv_fetch_fifo.sv
// Two-entry synchronous queue of fetched instructions; slot0 is always the head,
// so the head fields come straight from flops. Flush wins over push and pop.
module miriscv_fetch_fifo
    import miriscv_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [1:0]   count
);

    localparam logic [1:0] DEPTH_C = 2'(FETCH_QUEUE_DEPTH);

    fetch_entry_t slot0_r;
    fetch_entry_t slot1_r;
    logic [1:0]   count_r;
    logic         push_ok_s;
    logic         pop_ok_s;

    // Never write past the last slot nor read from an empty queue.
    always_comb begin
        push_ok_s = push && (count_r != DEPTH_C);
        pop_ok_s  = pop && (count_r != 2'd0);
    end

    // Queue storage and occupancy; pops shift slot1 down into the head slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_r <= FETCH_ENTRY_RESET;
            slot1_r <= FETCH_ENTRY_RESET;
            count_r <= 2'd0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        slot0_r <= wdata;
                    end else begin
                        slot1_r <= wdata;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    slot0_r <= slot1_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        slot0_r <= wdata;
                    end else begin
                        slot0_r <= slot1_r;
                        slot1_r <= wdata;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign rdata = slot0_r;
    assign count = count_r;

endmodule

// File: rtl/miriscv_fetch.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time word requests over
// req/gnt/rvalid and feeds decode from a two-entry queue. Redirects from execute
// flush the queue and turn any in-flight response into a discarded one.
module miriscv_fetch
    import miriscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] fetched_instr_o,
    output logic [31:0] fetched_pc_o,
    output logic        fetched_err_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    fetch_state_e state_r;
    logic [31:0]  pc_r;
    logic [31:0]  req_pc_r;
    logic [1:0]   count_s;
    fetch_entry_t head_s;
    fetch_entry_t push_entry_s;
    logic         rvalid_busy_s;
    logic         rvalid_keep_s;
    logic         pop_s;
    logic         push_s;
    logic         pending_s;
    logic [2:0]   occupancy_s;
    logic         req_s;
    logic         grant_s;
    logic         unused_s;

    // Low target bits are ignored; misalignment is execute's concern.
    assign unused_s = ^redirect_pc_i[1:0];

    // Handshake decode: a new request may go out in the response cycle, but only
    // if the queue will still have room for its eventual response.
    always_comb begin
        rvalid_busy_s = instr_rvalid_i && (state_r != FETCH_IDLE);
        rvalid_keep_s = instr_rvalid_i && (state_r == FETCH_WAIT);
        pop_s         = instr_valid_o && instr_ready_i && !redirect_i;
        push_s        = rvalid_keep_s && !redirect_i;
        pending_s     = rvalid_keep_s && !pop_s;
        occupancy_s   = {1'b0, count_s} + {2'b00, pending_s};
        req_s         = !rst_i && !redirect_i
                        && ((state_r == FETCH_IDLE) || rvalid_busy_s)
                        && (occupancy_s < 3'd2);
        grant_s       = req_s && instr_gnt_i;
        push_entry_s  = {req_pc_r, instr_rdata_i, instr_err_i};
    end

    // PC and outstanding-request tracking; redirect overrides everything else.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= FETCH_IDLE;
            pc_r     <= word_addr(RESET_PC[31:2]);
            req_pc_r <= word_addr(RESET_PC[31:2]);
        end else if (redirect_i) begin
            pc_r <= word_addr(redirect_pc_i[31:2]);
            if ((state_r != FETCH_IDLE) && !instr_rvalid_i) begin
                state_r <= FETCH_DROP;
            end else begin
                state_r <= FETCH_IDLE;
            end
        end else if (grant_s) begin
            pc_r     <= pc_r + 32'd4;
            req_pc_r <= pc_r;
            state_r  <= FETCH_WAIT;
        end else if (rvalid_busy_s) begin
            state_r <= FETCH_IDLE;
        end else begin
            state_r <= state_r;
        end
    end

    miriscv_fetch_fifo u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_i),
        .wdata (push_entry_s),
        .rdata (head_s),
        .count (count_s)
    );

    assign instr_req_o     = req_s;
    assign instr_addr_o    = pc_r;
    assign instr_valid_o   = (count_s != 2'd0);
    assign fetched_instr_o = head_s.instr;
    assign fetched_pc_o    = head_s.pc;
    assign fetched_err_o   = head_s.err;

endmodule

// File: tb/tb_miriscv_fetch.sv
// Self-checking bench for miriscv_fetch: directed scenarios followed by random
// traffic, checked against a program-order model of the instruction stream.
`timescale 1ns/1ps
module tb_miriscv_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = 32'h0;
    logic        instr_err_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic [31:0] fetched_instr_o;
    logic [31:0] fetched_pc_o;
    logic        fetched_err_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;

    always #5 clk = ~clk;

    miriscv_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .instr_err_i     (instr_err_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .fetched_instr_o (fetched_instr_o),
        .fetched_pc_o    (fetched_pc_o),
        .fetched_err_o   (fetched_err_o),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i)
    );

    int errors = 0;
    int checks = 0;

    // Program-order model: next PC decode should see, next PC fetch should request.
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    // Memory model: at most one response in flight.
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_delay = 0;
    int          min_delay = 0;
    int          max_delay = 0;
    // Request expectations after a redirect.
    logic        expect_req_next = 1'b0;
    logic        expect_req_on_rvalid = 1'b0;
    // Samples of the current cycle.
    logic        s_req, s_valid, s_err;
    logic [31:0] s_addr, s_pc, s_instr;
    int          consumed = 0;
    logic        seen_err_108 = 1'b0;
    logic        found;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h5cbd8683;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic errf(input logic [31:0] a);
        return (a == 32'h0000_0108) || ((a[6:2] == 5'h13) && (a >= 32'h0000_1000));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the models.
    task automatic tick(input logic rst, input logic gnt, input logic ready,
                        input logic redir, input logic [31:0] target);
        logic rv;
        @(negedge clk);
        rv = mem_busy && (mem_delay == 0) && !rst;
        rst_i          = rst;
        instr_gnt_i    = gnt;
        instr_ready_i  = ready;
        redirect_i     = redir;
        redirect_pc_i  = target;
        instr_rvalid_i = rv;
        instr_rdata_i  = rv ? memf(mem_addr) : $urandom;
        instr_err_i    = rv ? errf(mem_addr) : 1'($urandom_range(0, 1));
        #1;
        s_req   = instr_req_o;
        s_addr  = instr_addr_o;
        s_valid = instr_valid_o;
        s_pc    = fetched_pc_o;
        s_instr = fetched_instr_o;
        s_err   = fetched_err_o;
        if (rst) begin
            chk("req_in_reset", s_req, 1'b0);
        end else begin
            if (redir) chk("req_on_redirect", s_req, 1'b0);
            if (s_req) chk("req_addr", s_addr, exp_req);
            if (mem_busy && !rv) chk("single_outstanding", s_req, 1'b0);
            if (expect_req_next && !redir) chk("req_after_idle_redirect", s_req, 1'b1);
            if (expect_req_on_rvalid && rv && !redir) chk("req_on_dropped_rvalid", s_req, 1'b1);
            if (s_valid && ready && !redir) begin
                chk("out_pc", s_pc, exp_pc);
                chk("out_instr", s_instr, memf(exp_pc));
                chk("out_err", s_err, errf(exp_pc));
                if (exp_pc == 32'h0000_0108) seen_err_108 = s_err;
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
        end
        @(posedge clk);
        expect_req_next = 1'b0;
        if (rst) begin
            exp_pc = RESET_PC;
            exp_req = RESET_PC;
            expect_req_on_rvalid = 1'b0;
            expect_req_next = 1'b1;
            if (mem_busy) mem_delay = 0;
        end else begin
            if (rv) expect_req_on_rvalid = 1'b0;
            if (redir) begin
                exp_pc  = {target[31:2], 2'b00};
                exp_req = {target[31:2], 2'b00};
                if (mem_busy && !rv) expect_req_on_rvalid = 1'b1;
                else expect_req_next = 1'b1;
            end else if (s_req && gnt) begin
                exp_req = exp_req + 32'd4;
            end
            if (s_req && gnt) begin
                mem_busy  = 1'b1;
                mem_addr  = s_addr;
                mem_delay = $urandom_range(min_delay, max_delay);
            end else if (rv) begin
                mem_busy = 1'b0;
            end else if (mem_busy) begin
                mem_delay--;
            end
        end
    endtask

    initial begin
        exp_pc  = RESET_PC;
        exp_req = RESET_PC;

        // Reset, then first fetch with zero-wait memory.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("reset_valid", s_valid, 1'b0);
        chk("reset_instr", s_instr, NOP);
        chk("reset_pc", s_pc, 32'h0);
        chk("reset_err", s_err, 1'b0);
        chk("first_req", s_req, 1'b1);
        chk("first_addr", s_addr, 32'h0000_0100);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("valid_at_n1", s_valid, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("valid_at_n2", s_valid, 1'b1);
        chk("first_instr", s_instr, 32'h5cbd8683);
        chk("first_pc", s_pc, 32'h0000_0100);

        // Decode stalled: queue fills and requests stop.
        repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("full_req_low", s_req, 1'b0);
        chk("full_valid", s_valid, 1'b1);
        chk("full_head_pc", s_pc, 32'h0000_0100);

        // Decode ready with zero-wait memory: one instruction per cycle after refill.
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            if (i >= 4) chk("stream_valid", s_valid, 1'b1);
        end
        chk("err_0x108", seen_err_108, 1'b1);

        // Redirect while a request is in flight and the queue holds an entry.
        min_delay = 2;
        max_delay = 2;
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("pre_redirect_grant", s_req, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2002);
        chk("pre_redirect_valid", s_valid, 1'b1);
        min_delay = 0;
        max_delay = 0;
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("redirect_flush", s_valid, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("redirect_req", s_req, 1'b1);
        chk("redirect_addr", s_addr, 32'h0000_2000);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            if (s_valid) begin
                found = 1'b1;
                chk("redirect_first_pc", s_pc, 32'h0000_2000);
            end
        end
        if (!found) chk("redirect_valid_timeout", 32'd0, 32'd1);

        // Reset while waiting; the stale response lands in the first cycle after reset.
        min_delay = 3;
        max_delay = 3;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            if (s_req) found = 1'b1;
        end
        chk("wait_grant_seen", found, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        min_delay = 0;
        max_delay = 0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("post_reset_stale_rvalid", instr_rvalid_i, mem_busy ? 1'b0 : 1'b1);
        chk("post_reset_valid", s_valid, 1'b0);
        chk("restart_addr", s_addr, RESET_PC);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("stale_ignored", s_valid, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("restart_valid", s_valid, 1'b1);
        chk("restart_pc", s_pc, RESET_PC);

        // Random traffic against the program-order model.
        min_delay = 0;
        max_delay = 2;
        consumed = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? 32'hffff_fff6 : $urandom;
            tick(1'b0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 29) == 0, tgt);
        end
        chk("random_progress", consumed > 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
